riscv_test_monitor: RTL and testbench
=====================================

// Module: riscv_test_monitor
// PURPOSE
//  Synthesizable self-checking monitor for riscv-tests (rv32ui-p-*) programs on open_risc_v_soc.
//  Snoops the register-file write port and detects end-of-test: DONE_REG written non-zero.
//  After a settle window it compares RESULT_REG with PASS_VALUE and reports pass, fail or timeout.
//  It also reports cycle/retire counts and the failing test number, and restarts on clear_i for a new ROM image.
// PARAMETERS
//  DONE_REG     26      index of completion-flag register
//  RESULT_REG   27      index of result register
//  TESTNUM_REG  3       index of test-number register (gp)
//  PASS_VALUE   32'd1   RESULT_REG value meaning pass
//  SETTLE_CYC   2       cycles after done trigger before verdict (>=1)
//  TIMEOUT_CYC  100000  RUN cycles before timeout (>=1)
//  CNT_W        32      width of cycle/retire counters
//  TRACE_DEPTH  8       trace ring entries, power of 2 (trace feature only)
// PORTS
//  clk            in   1       core clock
//  rst            in   1       async reset, active low (0 = reset)
//  clear_i        in   1       sync restart into RUN, clears all state
//  wr_en_i        in   1       regfile write enable
//  wr_addr_i      in   5       regfile write index
//  wr_data_i      in   32      regfile write data
//  retire_i       in   1       one instruction retired this cycle
//  done_o         out  1       verdict valid (PASS|FAIL|TIMEOUT)
//  pass_o         out  1       test passed
//  fail_o         out  1       test failed (result mismatch)
//  timeout_o      out  1       no completion within TIMEOUT_CYC
//  result_o       out  32      captured RESULT_REG value
//  test_num_o     out  32      captured TESTNUM_REG value
//  cycle_cnt_o    out  CNT_W   RUN+SETTLE cycles, saturating
//  retire_cnt_o   out  CNT_W   retired instructions, saturating
//  trace_idx_i    in   log2(TRACE_DEPTH)   0 = newest entry
//  trace_o        out  37      {addr[4:0],data[31:0]} of selected entry
//  trace_cnt_o    out  log2(TRACE_DEPTH)+1 valid entries, saturates at TRACE_DEPTH
// BEHAVIOUR
//  - Reset: every output 0, every counter/shadow 0, FSM=RUN. rst asserted mid-test aborts it at once.
//  - States: RUN -> SETTLE (write DONE_REG with data!=0) | TIMEOUT (cycle_cnt reaches TIMEOUT_CYC);
//    SETTLE -> PASS/FAIL after SETTLE_CYC cycles; PASS/FAIL/TIMEOUT are terminal until clear_i or rst.
//  - Shadows: RESULT_REG and TESTNUM_REG writes update result_o/test_num_o in RUN and SETTLE, 1-cycle latency.
//    Writes to x0, or any write in a terminal state, are ignored.
//  - Verdict registered: pass_o=(result==PASS_VALUE), else fail_o; done_o rises with it.
//    The verdict appears SETTLE_CYC+1 cycles after the trigger write; exactly one of pass/fail/timeout is set.
//  - A write of 0 to DONE_REG does not trigger. A trigger and a timeout in the same cycle: the trigger wins.
//  - In SETTLE, a write to RESULT_REG in the final settle cycle is included in the verdict.
//  - Counters count only in RUN/SETTLE, saturate at all-ones, and freeze in terminal states.
//  - clear_i has priority over all other events that cycle. Next cycle: FSM=RUN, all outputs 0.
// CONFIGURATION
//  RISCV_TEST_MON_TRACE_EN defined: ring buffer of the last TRACE_DEPTH non-x0 writes.
//    The write pointer wraps modulo TRACE_DEPTH and the buffer is written in RUN/SETTLE only.
//    trace_o is combinational from trace_idx_i; idx>=trace_cnt_o returns 0. Buffer cleared by rst/clear_i.
//  RISCV_TEST_MON_TRACE_EN undefined: no storage; trace_o=0 and trace_cnt_o=0.
// TESTING
//  1 write x27=1, x3=5, then x26=1 -> SETTLE_CYC+1 cycles later pass_o=1, done_o=1, test_num_o=5
//  2 write x27=0, x3=7, then x26=1 -> fail_o=1, result_o=0, test_num_o=7, pass_o=0
//  3 x26=1 first, then x27=1 in last settle cycle -> pass_o=1
//  4 TIMEOUT_CYC=50, no x26 write -> timeout_o=1 at cycle 50, cycle_cnt_o=50, then frozen
//  5 x26=0 write, then x0=1 write -> no trigger, result_o unchanged; x26 write on timeout cycle -> pass/fail, not timeout
//  6 TRACE_EN, DEPTH=8: 10 writes, data 1..10 -> trace_cnt_o=8, idx0=10, idx7=3; clear_i -> trace_cnt_o=0, state RUN

Source files
------------

// File: rtl/riscv_test_monitor.sv
// End-of-test monitor for riscv-tests programs: snoops regfile writes and reports pass/fail/timeout.
// Optional trace ring buffer of recent non-x0 writes enabled by defining RISCV_TEST_MON_TRACE_EN.
module riscv_test_monitor #(
  parameter int unsigned DONE_REG    = 26,
  parameter int unsigned RESULT_REG  = 27,
  parameter int unsigned TESTNUM_REG = 3,
  parameter logic [31:0] PASS_VALUE  = 32'd1,
  parameter int unsigned SETTLE_CYC  = 2,
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TRACE_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear_i,
  input  logic                           wr_en_i,
  input  logic [4:0]                     wr_addr_i,
  input  logic [31:0]                    wr_data_i,
  input  logic                           retire_i,
  output logic                           done_o,
  output logic                           pass_o,
  output logic                           fail_o,
  output logic                           timeout_o,
  output logic [31:0]                    result_o,
  output logic [31:0]                    test_num_o,
  output logic [CNT_W-1:0]               cycle_cnt_o,
  output logic [CNT_W-1:0]               retire_cnt_o,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx_i,
  output logic [36:0]                    trace_o,
  output logic [$clog2(TRACE_DEPTH):0]   trace_cnt_o
);

  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [4:0] DONE_A    = 5'(DONE_REG);
  localparam logic [4:0] RESULT_A  = 5'(RESULT_REG);
  localparam logic [4:0] TESTNUM_A = 5'(TESTNUM_REG);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W:0] TO_LIM = (CNT_W + 1)'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_SETTLE  = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]      r_result;
  logic [31:0]      r_test_num;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_retire_cnt;
  logic [SET_W-1:0] r_settle_cnt;

  logic             w_active;
  logic             w_wr;
  logic             w_wr_done;
  logic             w_wr_result;
  logic             w_wr_testnum;
  logic [31:0]      w_result_nxt;
  logic             w_settle_last;
  logic [CNT_W:0]   w_cyc_inc;
  logic             w_timeout_hit;

  assign w_active      = (r_state == S_RUN) || (r_state == S_SETTLE);
  assign w_wr          = wr_en_i && (wr_addr_i != 5'd0) && w_active;
  assign w_wr_done     = w_wr && (wr_addr_i == DONE_A) && (wr_data_i != 32'd0);
  assign w_wr_result   = w_wr && (wr_addr_i == RESULT_A);
  assign w_wr_testnum  = w_wr && (wr_addr_i == TESTNUM_A);
  // A result write landing in the final settle cycle must feed the verdict directly.
  assign w_result_nxt  = w_wr_result ? wr_data_i : r_result;
  assign w_settle_last = (r_settle_cnt == SET_LAST);
  assign w_cyc_inc     = {1'b0, r_cycle_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_timeout_hit = (w_cyc_inc >= TO_LIM);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN: begin
        // Trigger takes precedence over a coincident timeout.
        if (w_wr_done) begin
          w_state_nxt = S_SETTLE;
        end else if (w_timeout_hit) begin
          w_state_nxt = S_TIMEOUT;
        end
      end
      S_SETTLE: begin
        if (w_settle_last) begin
          w_state_nxt = (w_result_nxt == PASS_VALUE) ? S_PASS : S_FAIL;
        end
      end
      default: w_state_nxt = r_state;
    endcase
    if (clear_i) begin
      w_state_nxt = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result     <= '0;
      r_test_num   <= '0;
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
      r_settle_cnt <= '0;
    end else if (clear_i) begin
      r_result     <= '0;
      r_test_num   <= '0;
      r_cycle_cnt  <= '0;
      r_retire_cnt <= '0;
      r_settle_cnt <= '0;
    end else begin
      if (w_wr_result) begin
        r_result <= wr_data_i;
      end
      if (w_wr_testnum) begin
        r_test_num <= wr_data_i;
      end
      if (w_active) begin
        if (!(&r_cycle_cnt)) begin
          r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
        if (retire_i && !(&r_retire_cnt)) begin
          r_retire_cnt <= r_retire_cnt + 1'b1;
        end
      end
      if ((r_state == S_RUN) && w_wr_done) begin
        r_settle_cnt <= '0;
      end else if ((r_state == S_SETTLE) && !w_settle_last) begin
        r_settle_cnt <= r_settle_cnt + 1'b1;
      end
    end
  end

  assign pass_o       = (r_state == S_PASS);
  assign fail_o       = (r_state == S_FAIL);
  assign timeout_o    = (r_state == S_TIMEOUT);
  assign done_o       = pass_o || fail_o || timeout_o;
  assign result_o     = r_result;
  assign test_num_o   = r_test_num;
  assign cycle_cnt_o  = r_cycle_cnt;
  assign retire_cnt_o = r_retire_cnt;

`ifdef RISCV_TEST_MON_TRACE_EN
  localparam int unsigned IDX_W = $clog2(TRACE_DEPTH);
  localparam logic [IDX_W:0] T_FULL = (IDX_W + 1)'(TRACE_DEPTH);

  logic [36:0]      r_trace_mem [TRACE_DEPTH];
  logic [IDX_W-1:0] r_wptr;
  logic [IDX_W:0]   r_tcnt;
  logic [IDX_W-1:0] w_rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_tcnt <= '0;
    end else if (clear_i) begin
      r_wptr <= '0;
      r_tcnt <= '0;
    end else if (w_wr) begin
      r_wptr <= r_wptr + 1'b1;
      if (r_tcnt != T_FULL) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
    end
  end

  // Storage is not reset; the valid count masks stale entries on readout.
  always_ff @(posedge clk) begin
    if (w_wr && !clear_i) begin
      r_trace_mem[r_wptr] <= {wr_addr_i, wr_data_i};
    end
  end

  assign w_rd_ptr    = r_wptr - IDX_W'(1) - trace_idx_i;
  assign trace_o     = ({1'b0, trace_idx_i} < r_tcnt) ? r_trace_mem[w_rd_ptr] : 37'd0;
  assign trace_cnt_o = r_tcnt;
`else
  logic w_unused_trace;
  assign w_unused_trace = ^trace_idx_i;
  assign trace_o        = '0;
  assign trace_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed, table-driven bench for riscv_test_monitor (SETTLE_CYC=2, TIMEOUT_CYC=50).
module tb_riscv_test_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear_i = 1'b0;
  logic        wr_en_i = 1'b0;
  logic [4:0]  wr_addr_i = '0;
  logic [31:0] wr_data_i = '0;
  logic        retire_i = 1'b0;
  logic [2:0]  trace_idx_i = '0;
  logic        done_o, pass_o, fail_o, timeout_o;
  logic [31:0] result_o, test_num_o, cycle_cnt_o, retire_cnt_o;
  logic [36:0] trace_o;
  logic [3:0]  trace_cnt_o;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] F_NONE = 4'b0000;  // {done,pass,fail,timeout}
  localparam logic [3:0] F_PASS = 4'b1100;
  localparam logic [3:0] F_FAIL = 4'b1010;
  localparam logic [3:0] F_TMO  = 4'b1001;

  always #5 clk = ~clk;

  riscv_test_monitor #(
    .SETTLE_CYC  (2),
    .TIMEOUT_CYC (50),
    .CNT_W       (32),
    .TRACE_DEPTH (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clear_i),
    .wr_en_i      (wr_en_i),
    .wr_addr_i    (wr_addr_i),
    .wr_data_i    (wr_data_i),
    .retire_i     (retire_i),
    .done_o       (done_o),
    .pass_o       (pass_o),
    .fail_o       (fail_o),
    .timeout_o    (timeout_o),
    .result_o     (result_o),
    .test_num_o   (test_num_o),
    .cycle_cnt_o  (cycle_cnt_o),
    .retire_cnt_o (retire_cnt_o),
    .trace_idx_i  (trace_idx_i),
    .trace_o      (trace_o),
    .trace_cnt_o  (trace_cnt_o)
  );

  typedef struct {
    logic        clr;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        ret;
    logic [3:0]  flags;
    logic [31:0] res;
    logic [31:0] tnum;
    logic [31:0] cyc;
    logic [31:0] rcnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic clr, input logic we, input logic [4:0] addr,
                              input logic [31:0] data, input logic ret, input logic [3:0] flags,
                              input logic [31:0] res, input logic [31:0] tnum,
                              input logic [31:0] cyc, input logic [31:0] rcnt);
    vec_t v;
    v.clr = clr; v.we = we; v.addr = addr; v.data = data; v.ret = ret;
    v.flags = flags; v.res = res; v.tnum = tnum; v.cyc = cyc; v.rcnt = rcnt;
    return v;
  endfunction

  task automatic drive(input logic clr, input logic we, input logic [4:0] addr,
                       input logic [31:0] data, input logic ret);
    clear_i   = clr;
    wr_en_i   = we;
    wr_addr_i = addr;
    wr_data_i = data;
    retire_i  = ret;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] f, input logic [31:0] r,
                         input logic [31:0] t, input logic [31:0] c, input logic [31:0] n);
    chk({tag, ".flags"},  {60'd0, done_o, pass_o, fail_o, timeout_o}, {60'd0, f});
    chk({tag, ".result"}, {32'd0, result_o},     {32'd0, r});
    chk({tag, ".testnum"},{32'd0, test_num_o},   {32'd0, t});
    chk({tag, ".cycles"}, {32'd0, cycle_cnt_o},  {32'd0, c});
    chk({tag, ".retires"},{32'd0, retire_cnt_o}, {32'd0, n});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // pass: x27=1, x3=5, x26=1
    vecs.push_back(mk(0,1,27,1,1, F_NONE,1,0,1,1));
    vecs.push_back(mk(0,1, 3,5,0, F_NONE,1,5,2,1));
    vecs.push_back(mk(0,1,26,1,1, F_NONE,1,5,3,2));
    vecs.push_back(mk(0,0, 0,0,0, F_NONE,1,5,4,2));
    vecs.push_back(mk(0,0, 0,0,0, F_PASS,1,5,5,2));
    vecs.push_back(mk(0,0, 0,0,1, F_PASS,1,5,5,2));
    vecs.push_back(mk(0,1,27,0,0, F_PASS,1,5,5,2));
    vecs.push_back(mk(1,1,27,9,0, F_NONE,0,0,0,0));
    // fail: x27=0, x3=7, x26=1
    vecs.push_back(mk(0,1,27,0,0, F_NONE,0,0,1,0));
    vecs.push_back(mk(0,1, 3,7,0, F_NONE,0,7,2,0));
    vecs.push_back(mk(0,1,26,1,0, F_NONE,0,7,3,0));
    vecs.push_back(mk(0,0, 0,0,0, F_NONE,0,7,4,0));
    vecs.push_back(mk(0,0, 0,0,0, F_FAIL,0,7,5,0));
    vecs.push_back(mk(1,0, 0,0,0, F_NONE,0,0,0,0));
    // result written in the final settle cycle
    vecs.push_back(mk(0,1,26,5,0, F_NONE,0,0,1,0));
    vecs.push_back(mk(0,0, 0,0,0, F_NONE,0,0,2,0));
    vecs.push_back(mk(0,1,27,1,0, F_PASS,1,0,3,0));
    vecs.push_back(mk(1,0, 0,0,0, F_NONE,0,0,0,0));
    // zero to x26 and writes to x0 do nothing
    vecs.push_back(mk(0,1,27,4,1, F_NONE,4,0,1,1));
    vecs.push_back(mk(0,1,26,0,0, F_NONE,4,0,2,1));
    vecs.push_back(mk(0,1, 0,1,0, F_NONE,4,0,3,1));
    vecs.push_back(mk(0,0, 0,0,0, F_NONE,4,0,4,1));
    vecs.push_back(mk(1,0, 0,0,0, F_NONE,0,0,0,0));
    // clear beats a simultaneous trigger
    vecs.push_back(mk(1,1,26,1,0, F_NONE,0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0, F_NONE,0,0,1,0));
    vecs.push_back(mk(0,0, 0,0,0, F_NONE,0,0,2,0));
    vecs.push_back(mk(0,0, 0,0,0, F_NONE,0,0,3,0));
    vecs.push_back(mk(0,0, 0,0,1, F_NONE,0,0,4,1));
    vecs.push_back(mk(1,0, 0,0,0, F_NONE,0,0,0,0));

    // reset state, with a write attempted during reset
    wr_en_i = 1'b1; wr_addr_i = 5'd27; wr_data_i = 32'd3;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", F_NONE, 0, 0, 0, 0);
    chk("reset.trace_cnt", {60'd0, trace_cnt_o}, 64'd0);
    wr_en_i = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].ret);
      chk_all($sformatf("vec%0d", i), vecs[i].flags, vecs[i].res, vecs[i].tnum,
              vecs[i].cyc, vecs[i].rcnt);
    end

    // timeout at cycle 50, then frozen and deaf to writes
    repeat (49) drive(0, 0, 0, 0, 1);
    chk_all("tmo.pre", F_NONE, 0, 0, 49, 49);
    drive(0, 0, 0, 0, 1);
    chk_all("tmo.hit", F_TMO, 0, 0, 50, 50);
    repeat (3) drive(0, 1, 27, 8, 1);
    chk_all("tmo.frozen", F_TMO, 0, 0, 50, 50);
    drive(1, 0, 0, 0, 0);
    chk_all("tmo.clear", F_NONE, 0, 0, 0, 0);

    // trigger on the timeout cycle wins
    drive(0, 1, 27, 1, 0);
    repeat (48) drive(0, 0, 0, 0, 0);
    chk_all("race.pre", F_NONE, 1, 0, 49, 0);
    drive(0, 1, 26, 1, 0);
    chk_all("race.trig", F_NONE, 1, 0, 50, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk_all("race.verdict", F_PASS, 1, 0, 52, 0);
    drive(1, 0, 0, 0, 0);

    // trace ring
    for (int i = 1; i <= 3; i++) drive(0, 1, 5, 32'(i), 0);
`ifdef RISCV_TEST_MON_TRACE_EN
    chk("trace.cnt3", {60'd0, trace_cnt_o}, 64'd3);
    trace_idx_i = 3'd3; #1;
    chk("trace.idx3_empty", {27'd0, trace_o}, 64'd0);
    trace_idx_i = 3'd0; #1;
    chk("trace.idx0_of3", {27'd0, trace_o}, {27'd0, 5'd5, 32'd3});
    for (int i = 4; i <= 10; i++) drive(0, 1, 5, 32'(i), 0);
    chk("trace.cnt_sat", {60'd0, trace_cnt_o}, 64'd8);
    trace_idx_i = 3'd0; #1;
    chk("trace.idx0", {27'd0, trace_o}, {27'd0, 5'd5, 32'd10});
    trace_idx_i = 3'd7; #1;
    chk("trace.idx7", {27'd0, trace_o}, {27'd0, 5'd5, 32'd3});
    trace_idx_i = 3'd3; #1;
    chk("trace.idx3", {27'd0, trace_o}, {27'd0, 5'd5, 32'd7});
    drive(1, 0, 0, 0, 0);
    chk("trace.clr_cnt", {60'd0, trace_cnt_o}, 64'd0);
    chk("trace.clr_data", {27'd0, trace_o}, 64'd0);
    chk_all("trace.clr", F_NONE, 0, 0, 0, 0);
`else
    for (int i = 0; i < 8; i++) begin
      trace_idx_i = 3'(i); #1;
      chk($sformatf("notrace.idx%0d", i), {27'd0, trace_o}, 64'd0);
    end
    chk("notrace.cnt", {60'd0, trace_cnt_o}, 64'd0);
    drive(1, 0, 0, 0, 0);
`endif

    // asynchronous reset in SETTLE aborts the test
    drive(0, 1, 27, 3, 0);
    drive(0, 1, 26, 1, 0);
    rst = 1'b0;
    #1;
    chk_all("arst.now", F_NONE, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) drive(0, 0, 0, 0, 0);
    chk_all("arst.after", F_NONE, 0, 0, 3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
